// File: rtl/snoop_cache_node.sv
// snoop_cache_node
// One processor node of a bus-snooping coherent L1 cache. Each line holds one
// word and uses a full-address tag. The protocol is MSI, or MESI when MESI_EN=1.
// Processor requests that miss or need an upgrade go through a single bus
// request. A dirty victim is written back before the line is refilled from
// memory. Snooped messages from other nodes update local lines in any FSM state.
// A write-back caused by a snoop waits in a one-entry pending register. It takes
// priority on the write-back port.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   cpu_valid/ready/proc/write/addr/wdata   processor request handshake
//   rd_valid, rd_data            one-cycle read completion pulse and data
//   bus_req/gnt, bus_msg, bus_addr          arbitrated coherence broadcast
//   snp_valid/src/msg/addr       snooped message from the shared bus
//   snp_shared_out/in            "line held here" indication out / OR of others in
//   wb_valid/ready/addr/data     write-back handshake toward memory
//   mem_rd/addr, mem_ack/data    memory read handshake for miss fills
module snoop_cache_node #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 3,
  parameter int NUM_LINES = 4,
  parameter int ID_W      = 2,
  parameter int NODE_ID   = 0,
  parameter bit MESI_EN   = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ID_W-1:0]   cpu_proc,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [1:0]        bus_msg,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              snp_valid,
  input  logic [ID_W-1:0]   snp_src,
  input  logic [1:0]        snp_msg,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              snp_shared_out,
  input  logic              snp_shared_in,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [ID_W-1:0] MY_ID = ID_W'(NODE_ID);

  localparam logic [1:0] MSG_INV  = 2'b00;
  localparam logic [1:0] MSG_RD   = 2'b01;
  localparam logic [1:0] MSG_WR   = 2'b10;
  localparam logic [1:0] MSG_NONE = 2'b11;

  typedef enum logic [1:0] {
    LS_I = 2'b00,
    LS_M = 2'b01,
    LS_S = 2'b10,
    LS_E = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE,
    BUSREQ,
    VWB,
    MEMRD,
    DONE
  } fsm_t;

  fsm_t                fsm, fsm_n;
  line_state_t         line_st   [NUM_LINES];
  line_state_t         st_n      [NUM_LINES];
  logic [ADDR_W-1:0]   line_tag  [NUM_LINES];
  logic [ADDR_W-1:0]   tag_n     [NUM_LINES];
  logic [DATA_W-1:0]   line_data [NUM_LINES];
  logic [DATA_W-1:0]   data_n    [NUM_LINES];

  logic                req_write, req_write_n;
  logic [ADDR_W-1:0]   req_addr, req_addr_n;
  logic [DATA_W-1:0]   req_wdata, req_wdata_n;
  logic                shared_q, shared_n;
  logic [DATA_W-1:0]   fill_data, fill_n;
  logic                rd_pulse, rd_pulse_n;
  logic [DATA_W-1:0]   rd_hold, rd_hold_n;
  logic                pend, pend_n;
  logic [ADDR_W-1:0]   pend_addr, pend_addr_n;
  logic [DATA_W-1:0]   pend_data, pend_data_n;

  logic [IDX_W-1:0]    snp_idx, cpu_idx, req_idx;
  logic                snp_match, snp_act, snp_wb;
  line_state_t         snp_new_st, cpu_eff, req_eff;
  logic                cpu_hit, req_hit;

  // Snoop decode: a foreign message is compared against the resident line.
  // snp_shared_out reports any non-I match. Message 11 carries no update.
  always_comb begin
    snp_idx    = snp_addr[IDX_W-1:0];
    snp_match  = snp_valid && (snp_src != MY_ID) &&
                 (line_st[snp_idx] != LS_I) && (line_tag[snp_idx] == snp_addr);
    snp_act    = snp_match && (snp_msg != MSG_NONE);
    snp_wb     = snp_act && (line_st[snp_idx] == LS_M);
    snp_new_st = (snp_msg == MSG_RD) ? LS_S : LS_I;
  end

  assign snp_shared_out = snp_match;

  assign rd_valid = rd_pulse || ((fsm == DONE) && !req_write);
  assign rd_data  = (fsm == DONE) ? fill_data : rd_hold;

  // Next-state and output logic. The snoop update is applied to the next line
  // arrays first. Processor-side decisions then use the post-snoop line state,
  // and any processor write to the same line overrides the snoop result.
  always_comb begin
    fsm_n       = fsm;
    st_n        = line_st;
    tag_n       = line_tag;
    data_n      = line_data;
    req_write_n = req_write;
    req_addr_n  = req_addr;
    req_wdata_n = req_wdata;
    shared_n    = shared_q;
    fill_n      = fill_data;
    rd_pulse_n  = 1'b0;
    rd_hold_n   = rd_hold;
    pend_n      = pend;
    pend_addr_n = pend_addr;
    pend_data_n = pend_data;
    cpu_ready   = (fsm == IDLE) && !pend;
    bus_req     = 1'b0;
    bus_msg     = MSG_NONE;
    bus_addr    = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    cpu_idx     = cpu_addr[IDX_W-1:0];
    req_idx     = req_addr[IDX_W-1:0];

    if (snp_act) st_n[snp_idx] = snp_new_st;
    if (snp_wb) begin
      pend_n      = 1'b1;
      pend_addr_n = line_tag[snp_idx];
      pend_data_n = line_data[snp_idx];
    end

    // A pending snoop write-back owns the port. The victim write-back is only
    // offered while the victim is still dirty, because a snoop may already
    // have taken the data away.
    if (pend) begin
      wb_valid = 1'b1;
      wb_addr  = pend_addr;
      wb_data  = pend_data;
      if (wb_ready && !snp_wb) pend_n = 1'b0;
    end else if ((fsm == VWB) && (line_st[req_idx] == LS_M)) begin
      wb_valid = 1'b1;
      wb_addr  = line_tag[req_idx];
      wb_data  = line_data[req_idx];
    end

    cpu_eff = st_n[cpu_idx];
    req_eff = st_n[req_idx];
    cpu_hit = (cpu_eff != LS_I) && (line_tag[cpu_idx] == cpu_addr);
    req_hit = (req_eff != LS_I) && (line_tag[req_idx] == req_addr);

    case (fsm)
      IDLE: begin
        if (cpu_valid && cpu_ready && (cpu_proc == MY_ID)) begin
          if (!cpu_write && cpu_hit) begin
            rd_pulse_n = 1'b1;
            rd_hold_n  = line_data[cpu_idx];
          end else if (cpu_write && cpu_hit && (cpu_eff != LS_S)) begin
            data_n[cpu_idx] = cpu_wdata;
            st_n[cpu_idx]   = LS_M;
          end else begin
            req_write_n = cpu_write;
            req_addr_n  = cpu_addr;
            req_wdata_n = cpu_wdata;
            fsm_n       = BUSREQ;
          end
        end
      end
      // The message is chosen at grant. An upgrade whose S line was
      // invalidated while waiting becomes an ordinary write miss.
      BUSREQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          bus_addr = req_addr;
          shared_n = snp_shared_in;
          if (req_write && req_hit) begin
            bus_msg         = MSG_INV;
            data_n[req_idx] = req_wdata;
            st_n[req_idx]   = LS_M;
            fsm_n           = IDLE;
          end else begin
            bus_msg = req_write ? MSG_WR : MSG_RD;
            if (req_eff == LS_M) begin
              fsm_n = VWB;
            end else begin
              st_n[req_idx] = LS_I;
              fsm_n         = req_write ? DONE : MEMRD;
            end
          end
        end
      end
      VWB: begin
        if (!pend && ((line_st[req_idx] != LS_M) || wb_ready)) begin
          st_n[req_idx] = LS_I;
          fsm_n         = req_write ? DONE : MEMRD;
        end
      end
      MEMRD: begin
        mem_rd   = 1'b1;
        mem_addr = req_addr;
        if (mem_ack) begin
          fill_n = mem_data;
          fsm_n  = DONE;
        end
      end
      DONE: begin
        tag_n[req_idx] = req_addr;
        if (req_write) begin
          data_n[req_idx] = req_wdata;
          st_n[req_idx]   = LS_M;
        end else begin
          data_n[req_idx] = fill_data;
          st_n[req_idx]   = (MESI_EN && !shared_q) ? LS_E : LS_S;
        end
        fsm_n = IDLE;
      end
      default: fsm_n = IDLE;
    endcase
  end

  // State register. Reset drops any in-flight request or write-back immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm <= IDLE;
      for (int i = 0; i < NUM_LINES; i++) begin
        line_st[i]   <= LS_I;
        line_tag[i]  <= '0;
        line_data[i] <= '0;
      end
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      shared_q  <= 1'b0;
      fill_data <= '0;
      rd_pulse  <= 1'b0;
      rd_hold   <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      fsm       <= fsm_n;
      line_st   <= st_n;
      line_tag  <= tag_n;
      line_data <= data_n;
      req_write <= req_write_n;
      req_addr  <= req_addr_n;
      req_wdata <= req_wdata_n;
      shared_q  <= shared_n;
      fill_data <= fill_n;
      rd_pulse  <= rd_pulse_n;
      rd_hold   <= rd_hold_n;
      pend      <= pend_n;
      pend_addr <= pend_addr_n;
      pend_data <= pend_data_n;
    end
  end

endmodule

// File: tb/tb_snoop_cache_node.sv
// tb_snoop_cache_node
// Self-checking bench for snoop_cache_node. It contains an MSI instance
// (slot 0) and a MESI instance (slot 1). Only the instance selected by 'sel'
// sees valid, grant and ack inputs. The bench plays the bus, arbiter and memory.
// A line-level model predicts every observable output.
module tb_snoop_cache_node;

  typedef enum {MI, MS, ME, MM} mst_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_valid, cpu_write;
  logic [1:0] cpu_proc;
  logic [2:0] cpu_addr, cpu_wdata;
  logic       snp_valid, snp_shared_in;
  logic [1:0] snp_src, snp_msg;
  logic [2:0] snp_addr;
  logic       bus_gnt, wb_ready, mem_ack;
  logic [2:0] mem_data;
  bit         sel;

  logic       cpu_ready_w [2];
  logic       rd_valid_w  [2];
  logic [2:0] rd_data_w   [2];
  logic       bus_req_w   [2];
  logic [1:0] bus_msg_w   [2];
  logic [2:0] bus_addr_w  [2];
  logic       snp_shared_w[2];
  logic       wb_valid_w  [2];
  logic [2:0] wb_addr_w   [2];
  logic [2:0] wb_data_w   [2];
  logic       mem_rd_w    [2];
  logic [2:0] mem_addr_w  [2];

  mst_t       m_st   [2][4];
  logic [2:0] m_tag  [2][4];
  logic [2:0] m_data [2][4];

  int errors = 0;
  int checks = 0;
  int force_shin = -1;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    snoop_cache_node #(.MESI_EN(g == 1)) dut (
      .clock(clock), .reset(reset),
      .cpu_valid(cpu_valid && (sel == g)), .cpu_ready(cpu_ready_w[g]),
      .cpu_proc(cpu_proc), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .rd_valid(rd_valid_w[g]), .rd_data(rd_data_w[g]),
      .bus_req(bus_req_w[g]), .bus_gnt(bus_gnt && (sel == g)),
      .bus_msg(bus_msg_w[g]), .bus_addr(bus_addr_w[g]),
      .snp_valid(snp_valid && (sel == g)), .snp_src(snp_src), .snp_msg(snp_msg),
      .snp_addr(snp_addr), .snp_shared_out(snp_shared_w[g]),
      .snp_shared_in(snp_shared_in), .wb_valid(wb_valid_w[g]),
      .wb_ready(wb_ready && (sel == g)), .wb_addr(wb_addr_w[g]),
      .wb_data(wb_data_w[g]), .mem_rd(mem_rd_w[g]), .mem_addr(mem_addr_w[g]),
      .mem_ack(mem_ack && (sel == g)), .mem_data(mem_data)
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic resetModel();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) begin
        m_st[s][i]   = MI;
        m_tag[s][i]  = 3'd0;
        m_data[s][i] = 3'd0;
      end
  endtask

  task automatic waitReady();
    for (int i = 0; i < 8 && cpu_ready_w[sel] !== 1'b1; i++) tick();
    checkOutput("ready_timeout", cpu_ready_w[sel], 1);
  endtask

  // One processor request from this node, serviced to completion by the bench.
  // With inj set (only for a write to an S line), a foreign invalidate of the
  // same address is snooped while the grant is held off.
  task automatic applyStimulus(input bit wr, input logic [2:0] addr,
                               input logic [2:0] wdata, input bit inj);
    int idx;
    bit hit;
    int gdelay;
    logic shin;
    logic [2:0] md;
    logic [1:0] emsg;
    idx = int'(addr[1:0]);
    hit = (m_st[sel][idx] != MI) && (m_tag[sel][idx] == addr);
    checkOutput("ready_before_req", cpu_ready_w[sel], 1);
    cpu_valid = 1'b1; cpu_proc = 2'd0; cpu_write = wr;
    cpu_addr = addr; cpu_wdata = wdata;
    tick();
    cpu_valid = 1'b0;
    if (!wr && hit) begin
      checkOutput("hit_rd_valid", rd_valid_w[sel], 1);
      checkOutput("hit_rd_data", rd_data_w[sel], m_data[sel][idx]);
      checkOutput("hit_bus_silent", bus_req_w[sel], 0);
    end else if (wr && hit && m_st[sel][idx] != MS) begin
      checkOutput("wrhit_bus_silent", bus_req_w[sel], 0);
      checkOutput("wrhit_no_rd", rd_valid_w[sel], 0);
      m_data[sel][idx] = wdata;
      m_st[sel][idx]   = MM;
    end else begin
      checkOutput("bus_req", bus_req_w[sel], 1);
      gdelay = inj ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
      for (int i = 0; i < gdelay; i++) begin
        if (inj && i == 0) begin
          snp_valid = 1'b1; snp_src = 2'd1; snp_msg = 2'b00; snp_addr = addr;
          #1;
          checkOutput("inj_shared", snp_shared_w[sel], 1);
          m_st[sel][idx] = MI;
        end
        checkOutput("msg_idle_wait", bus_msg_w[sel], 2'b11);
        tick();
        snp_valid = 1'b0;
      end
      hit  = (m_st[sel][idx] != MI) && (m_tag[sel][idx] == addr);
      shin = (force_shin < 0) ? 1'($urandom) : 1'(force_shin);
      bus_gnt = 1'b1; snp_shared_in = shin;
      #1;
      emsg = (wr && hit) ? 2'b00 : (wr ? 2'b10 : 2'b01);
      checkOutput("grant_msg", bus_msg_w[sel], emsg);
      checkOutput("grant_addr", bus_addr_w[sel], addr);
      tick();
      bus_gnt = 1'b0;
      if (wr && hit) begin
        m_data[sel][idx] = wdata;
        m_st[sel][idx]   = MM;
      end else begin
        if (m_st[sel][idx] == MM) begin
          checkOutput("victim_wb_valid", wb_valid_w[sel], 1);
          checkOutput("victim_wb_addr", wb_addr_w[sel], m_tag[sel][idx]);
          checkOutput("victim_wb_data", wb_data_w[sel], m_data[sel][idx]);
          repeat ($urandom_range(0, 2)) tick();
          wb_ready = 1'b1;
          tick();
          wb_ready = 1'b0;
        end
        if (!wr) begin
          checkOutput("mem_rd", mem_rd_w[sel], 1);
          checkOutput("mem_addr", mem_addr_w[sel], addr);
          repeat ($urandom_range(0, 2)) tick();
          md = 3'($urandom);
          mem_ack = 1'b1; mem_data = md;
          tick();
          mem_ack = 1'b0;
          checkOutput("fill_rd_valid", rd_valid_w[sel], 1);
          checkOutput("fill_rd_data", rd_data_w[sel], md);
          m_data[sel][idx] = md;
          m_st[sel][idx]   = (sel && !shin) ? ME : MS;
        end else begin
          checkOutput("wrmiss_no_memrd", mem_rd_w[sel], 0);
          m_data[sel][idx] = wdata;
          m_st[sel][idx]   = MM;
        end
        m_tag[sel][idx] = addr;
      end
      waitReady();
    end
  endtask

  // One foreign (or self-sourced, hence ignored) snooped message while idle.
  task automatic applySnoop(input logic [1:0] src, input logic [1:0] msg, input logic [2:0] addr);
    int idx;
    bit match;
    idx = int'(addr[1:0]);
    match = (src != 2'd0) && (m_st[sel][idx] != MI) && (m_tag[sel][idx] == addr);
    snp_valid = 1'b1; snp_src = src; snp_msg = msg; snp_addr = addr;
    #1;
    checkOutput("snp_shared_out", snp_shared_w[sel], match);
    tick();
    snp_valid = 1'b0;
    if (match && msg != 2'b11) begin
      if (m_st[sel][idx] == MM) begin
        checkOutput("snp_wb_valid", wb_valid_w[sel], 1);
        checkOutput("snp_wb_addr", wb_addr_w[sel], m_tag[sel][idx]);
        checkOutput("snp_wb_data", wb_data_w[sel], m_data[sel][idx]);
        checkOutput("snp_wb_blocks_cpu", cpu_ready_w[sel], 0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
      end
      m_st[sel][idx] = (msg == 2'b01) ? MS : MI;
    end
    checkOutput("snp_wb_idle", wb_valid_w[sel], 0);
    checkOutput("snp_ready", cpu_ready_w[sel], 1);
  endtask

  task automatic randomPhase(input int n);
    int r;
    logic [2:0] a, d;
    bit wr, inj;
    for (int k = 0; k < n; k++) begin
      r = int'($urandom_range(0, 9));
      a = 3'($urandom);
      d = 3'($urandom);
      if (r < 5) begin
        wr  = 1'($urandom);
        inj = wr && (m_st[sel][a[1:0]] == MS) && (m_tag[sel][a[1:0]] == a) && 1'($urandom);
        applyStimulus(wr, a, d, inj);
      end else if (r < 8) begin
        if ($urandom_range(0, 1) == 1) a = m_tag[sel][$urandom_range(0, 3)];
        applySnoop(2'($urandom), 2'($urandom), a);
      end else begin
        cpu_valid = 1'b1; cpu_proc = 2'($urandom_range(1, 3));
        cpu_write = 1'($urandom); cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_valid = 1'b0;
        checkOutput("foreign_no_bus", bus_req_w[sel], 0);
        checkOutput("foreign_no_rd", rd_valid_w[sel], 0);
        checkOutput("foreign_ready", cpu_ready_w[sel], 1);
      end
    end
  endtask

  // Directed scenarios first, then randomized traffic, for each protocol flavour.
  initial begin
    reset = 1'b1; sel = 1'b0;
    cpu_valid = 0; cpu_write = 0; cpu_proc = 0; cpu_addr = 0; cpu_wdata = 0;
    snp_valid = 0; snp_src = 0; snp_msg = 0; snp_addr = 0; snp_shared_in = 0;
    bus_gnt = 0; wb_ready = 0; mem_ack = 0; mem_data = 0;
    resetModel();
    #12;
    checkOutput("rst_cpu_ready", cpu_ready_w[0], 1);
    checkOutput("rst_bus_req", bus_req_w[0], 0);
    checkOutput("rst_bus_msg", bus_msg_w[0], 2'b11);
    checkOutput("rst_bus_addr", bus_addr_w[0], 0);
    checkOutput("rst_rd_valid", rd_valid_w[0], 0);
    checkOutput("rst_rd_data", rd_data_w[0], 0);
    checkOutput("rst_wb_valid", wb_valid_w[0], 0);
    checkOutput("rst_mem_rd", mem_rd_w[0], 0);
    checkOutput("rst_shared", snp_shared_w[0], 0);
    reset = 1'b0;
    tick();

    applyStimulus(1'b1, 3'd2, 3'd4, 1'b0);
    applyStimulus(1'b0, 3'd2, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd5, 3'd3, 1'b0);
    applyStimulus(1'b0, 3'd1, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd4, 3'd7, 1'b0);
    applySnoop(2'd1, 2'b01, 3'd4);
    applySnoop(2'd1, 2'b10, 3'd4);
    applySnoop(2'd1, 2'b01, 3'd2);
    applyStimulus(1'b1, 3'd2, 3'd5, 1'b1);
    applyStimulus(1'b0, 3'd2, 3'd0, 1'b0);

    $display("[TB] reset during memory read");
    cpu_valid = 1'b1; cpu_proc = 2'd0; cpu_write = 1'b0; cpu_addr = 3'd7;
    tick();
    cpu_valid = 1'b0;
    checkOutput("mr_bus_req", bus_req_w[0], 1);
    bus_gnt = 1'b1; snp_shared_in = 1'b1;
    tick();
    bus_gnt = 1'b0;
    checkOutput("mr_mem_rd", mem_rd_w[0], 1);
    reset = 1'b1;
    #1;
    checkOutput("mr_rst_mem_rd", mem_rd_w[0], 0);
    checkOutput("mr_rst_ready", cpu_ready_w[0], 1);
    checkOutput("mr_rst_bus_req", bus_req_w[0], 0);
    #2;
    reset = 1'b0;
    resetModel();
    tick();
    for (int a = 0; a < 8; a++) applySnoop(2'd1, 2'b11, 3'(a));
    randomPhase(150);

    $display("[TB] MESI instance");
    sel = 1'b1;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    resetModel();
    tick();
    force_shin = 0;
    applyStimulus(1'b0, 3'd3, 3'd0, 1'b0);
    force_shin = -1;
    applyStimulus(1'b1, 3'd3, 3'd1, 1'b0);
    applySnoop(2'd2, 2'b01, 3'd3);
    randomPhase(150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
